// File: rtl/definitions_pkg.sv
// +----------------------------------------------------------------------------+
// | definitions_pkg : shared codes, edge levels and FSM states                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package definitions_pkg;

   typedef enum logic [1:0] {
      NONE   = 2'b00,
      WEAK   = 2'b01,
      STRONG = 2'b10
   } str_code_t;

   localparam logic [7:0] EDGE_ON  = 8'hff;
   localparam logic [7:0] EDGE_OFF = 8'h00;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } hys_state_t;

   // Reserved code 11 never counts as strong.
   function automatic logic is_strong(input logic [1:0] code);
      return code == STRONG;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hys_line_buffer.sv
// +----------------------------------------------------------------------------+
// | hys_line_buffer : DEPTH-entry 2-bit shift register, oldest entry on dout_o |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module hys_line_buffer #(
   parameter int DEPTH = 640
) (
   input  logic       clk,
   input  logic       en_i,
   input  logic [1:0] din_i,
   output logic [1:0] dout_o
);

   logic [1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (en_i) begin
         mem_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) begin
            mem_q[i] <= mem_q[i-1];
         end
      end
   end

   assign dout_o = mem_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/hysteresis_stream.sv
// +----------------------------------------------------------------------------+
// | hysteresis_stream : streaming 3x3 hysteresis edge linking                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module hysteresis_stream
   import definitions_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int CONN8 = 1
) (
   input  logic       clk,
   input  logic       rstN,
   input  logic [1:0] str_in,
   input  logic       str_in_valid,
   output logic       str_in_ready,
   output logic [7:0] edge_out,
   output logic       edge_out_valid,
   input  logic       edge_out_ready,
   output logic       edge_out_last
);

   localparam int            CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int            RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);
   localparam logic          DIAG_EN  = (CONN8 != 0);

   hys_state_t    state_q, state_d;
   logic [CW-1:0] in_col_q, in_col_d, out_col_q, out_col_d;
   logic [RW-1:0] in_row_q, in_row_d, out_row_q, out_row_d;
   logic [7:0]    edge_q, edge_d;
   logic          valid_q, valid_d, last_q, last_d;

   // win_q[0] is the older column; together with the entering column nw[2] it forms the 3x3 view.
   logic [1:0]    win_q [2][3];
   logic [1:0]    nw    [3][3];
   logic [1:0]    new_px, lb0_tap, lb1_tap;
   logic          slot_free, in_acc, flush_load, advance, produce;
   logic          m_top, m_bot, m_left, m_right, orth_hit, diag_hit, centre_on;

   assign slot_free    = !valid_q || edge_out_ready;
   assign str_in_ready = rstN && (state_q != ST_FLUSH) && slot_free;
   assign in_acc       = str_in_valid && str_in_ready;
   assign flush_load   = (state_q == ST_FLUSH) && slot_free && !(valid_q && last_q);
   assign advance      = in_acc || flush_load;
   assign produce      = flush_load || (in_acc && (state_q == ST_RUN));
   assign new_px       = in_acc ? str_in : NONE;

   hys_line_buffer #(.DEPTH(IMG_W)) u_lb0 (
      .clk    (clk),
      .en_i   (advance),
      .din_i  (new_px),
      .dout_o (lb0_tap)
   );

   hys_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
      .clk    (clk),
      .en_i   (advance),
      .din_i  (lb0_tap),
      .dout_o (lb1_tap)
   );

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         nw[0][r] = win_q[0][r];
         nw[1][r] = win_q[1][r];
      end
      nw[2][0] = lb1_tap;
      nw[2][1] = lb0_tap;
      nw[2][2] = new_px;
   end

   // Border masks also hide stale line-buffer data and the previous row's tail.
   assign m_top    = (out_row_q != '0);
   assign m_bot    = (out_row_q != ROW_LAST);
   assign m_left   = (out_col_q != '0);
   assign m_right  = (out_col_q != COL_LAST);

   assign orth_hit = (m_top   && is_strong(nw[1][0])) || (m_bot   && is_strong(nw[1][2])) ||
                     (m_left  && is_strong(nw[0][1])) || (m_right && is_strong(nw[2][1]));
   assign diag_hit = (m_top && m_left  && is_strong(nw[0][0])) ||
                     (m_top && m_right && is_strong(nw[2][0])) ||
                     (m_bot && m_left  && is_strong(nw[0][2])) ||
                     (m_bot && m_right && is_strong(nw[2][2]));
   assign centre_on = is_strong(nw[1][1]) ||
                      ((nw[1][1] == WEAK) && (orth_hit || (DIAG_EN && diag_hit)));

   always_comb begin
      state_d   = state_q;
      in_col_d  = in_col_q;
      in_row_d  = in_row_q;
      out_col_d = out_col_q;
      out_row_d = out_row_q;
      edge_d    = edge_q;
      valid_d   = valid_q;
      last_d    = last_q;
      if (valid_q && edge_out_ready) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
      if (produce) begin
         edge_d  = centre_on ? EDGE_ON : EDGE_OFF;
         valid_d = 1'b1;
         last_d  = (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);
         if (out_col_q == COL_LAST) begin
            out_col_d = '0;
            out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
         end else begin
            out_col_d = out_col_q + 1'b1;
         end
      end
      if (in_acc) begin
         if (in_col_q == COL_LAST) begin
            in_col_d = '0;
            in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
         end else begin
            in_col_d = in_col_q + 1'b1;
         end
         if ((state_q == ST_FILL) && (in_row_q == ROW_ONE) && (in_col_q == '0)) begin
            state_d = ST_RUN;
         end else if ((state_q == ST_RUN) && (in_row_q == ROW_LAST) && (in_col_q == COL_LAST)) begin
            state_d = ST_FLUSH;
         end
      end
      if ((state_q == ST_FLUSH) && valid_q && last_q && edge_out_ready) begin
         state_d = ST_FILL;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q   <= ST_FILL;
         in_col_q  <= '0;
         in_row_q  <= '0;
         out_col_q <= '0;
         out_row_q <= '0;
         edge_q    <= EDGE_OFF;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_col_q  <= in_col_d;
         in_row_q  <= in_row_d;
         out_col_q <= out_col_d;
         out_row_q <= out_row_d;
         edge_q    <= edge_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         for (int r = 0; r < 3; r++) begin
            win_q[0][r] <= win_q[1][r];
            win_q[1][r] <= nw[2][r];
         end
      end
   end

   assign edge_out       = edge_q;
   assign edge_out_valid = valid_q;
   assign edge_out_last  = last_q;

endmodule

`default_nettype wire

// File: tb/tb_hysteresis_stream.sv
// +----------------------------------------------------------------------------+
// | tb_hysteresis_stream : directed 4x3 frames on 8- and 4-connected instances |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hysteresis_stream;

   typedef logic [1:0] frame_t [12];

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic [1:0] str_in = 2'b00;
   logic       str_in_valid = 1'b0;
   logic       edge_out_ready = 1'b1;
   logic       rdy8, v8, l8, rdy4, v4, l4;
   logic [7:0] eo8, eo4;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [8:0] q8 [$];
   logic [8:0] q4 [$];
   int         first_cyc, last_cyc, acc5_cyc;
   logic       stall_p;
   logic [8:0] held;

   always #5 clk = ~clk;

   hysteresis_stream #(.IMG_W(4), .IMG_H(3), .CONN8(1)) dut8 (
      .clk(clk), .rstN(rstN), .str_in(str_in), .str_in_valid(str_in_valid),
      .str_in_ready(rdy8), .edge_out(eo8), .edge_out_valid(v8),
      .edge_out_ready(edge_out_ready), .edge_out_last(l8)
   );

   hysteresis_stream #(.IMG_W(4), .IMG_H(3), .CONN8(0)) dut4 (
      .clk(clk), .rstN(rstN), .str_in(str_in), .str_in_valid(str_in_valid),
      .str_in_ready(rdy4), .edge_out(eo4), .edge_out_valid(v4),
      .edge_out_ready(edge_out_ready), .edge_out_last(l4)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Build a frame from bit masks: reserved wins over strong, strong over weak.
   task automatic mk(input logic [11:0] s, input logic [11:0] w, input logic [11:0] x,
                     output frame_t f);
      for (int i = 0; i < 12; i++) begin
         f[i] = x[i] ? 2'b11 : s[i] ? 2'b10 : w[i] ? 2'b01 : 2'b00;
      end
   endtask

   function automatic logic [11:0] model_mask(input frame_t f, input bit c8);
      logic [11:0] m;
      int rr, cc;
      m = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (f[r*4+c] == 2'b10) begin
               m[r*4+c] = 1'b1;
            end else if (f[r*4+c] == 2'b01) begin
               for (int dr = -1; dr <= 1; dr++) begin
                  for (int dc = -1; dc <= 1; dc++) begin
                     rr = r + dr;
                     cc = c + dc;
                     if ((dr != 0 || dc != 0) && (c8 || dr == 0 || dc == 0) &&
                         rr >= 0 && rr < 3 && cc >= 0 && cc < 4) begin
                        if (f[rr*4+cc] == 2'b10) m[r*4+c] = 1'b1;
                     end
                  end
               end
            end
         end
      end
      return m;
   endfunction

   task automatic observe(input int cyc);
      if (stall_p) check_eq("stall_hold", {23'd0, v8, eo8}, {23'd0, held});
      if (v8 && edge_out_ready) begin
         q8.push_back({l8, eo8});
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
      end
      if (v4 && edge_out_ready) q4.push_back({l4, eo4});
      stall_p = v8 && !edge_out_ready;
      held    = {v8, eo8};
   endtask

   // Called right after a rising edge; returns right after a rising edge.
   task automatic run_frame(input frame_t f, input int n_in, input bit rnd, input int n_out);
      int  idx, cyc;
      logic acc;
      idx = 0; cyc = 0;
      first_cyc = -1; last_cyc = -1; acc5_cyc = -1;
      stall_p = 1'b0; held = '0;
      q8.delete(); q4.delete();
      while (cyc < 400 && (idx < n_in || q8.size() < n_out)) begin
         edge_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         str_in_valid   = (idx < n_in);
         str_in         = (idx < n_in) ? f[idx] : 2'b00;
         @(negedge clk);
         acc = str_in_valid && rdy8;
         if (acc && idx == 4) acc5_cyc = cyc;
         observe(cyc);
         @(posedge clk); #1;
         if (acc) idx++;
         cyc++;
      end
      str_in_valid   = 1'b0;
      edge_out_ready = 1'b1;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         observe(cyc);
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic check_frame(input string name, input logic [11:0] m8, input logic [11:0] m4);
      check_eq({name, "_cnt8"}, q8.size(), 12);
      check_eq({name, "_cnt4"}, q4.size(), 12);
      for (int i = 0; i < 12; i++) begin
         if (i < q8.size())
            check_eq($sformatf("%s_c8_px%0d", name, i), {23'd0, q8[i]},
                     {23'd0, (i == 11), (m8[i] ? 8'hff : 8'h00)});
         if (i < q4.size())
            check_eq($sformatf("%s_c4_px%0d", name, i), {23'd0, q4[i]},
                     {23'd0, (i == 11), (m4[i] ? 8'hff : 8'h00)});
      end
   endtask

   task automatic do_reset();
      rstN = 1'b0; str_in_valid = 1'b0; str_in = 2'b00; edge_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ready8", rdy8, 0);
      check_eq("rst_ready4", rdy4, 0);
      check_eq("rst_valid8", v8, 0);
      check_eq("rst_valid4", v4, 0);
      check_eq("rst_edge", eo8, 0);
      check_eq("rst_last", l8, 0);
      @(posedge clk); #1;
      rstN = 1'b1;
      @(negedge clk);
      check_eq("rel_ready", rdy8, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_t f, g;
      do_reset();

      mk(12'hFFF, 12'h000, 12'h000, f);
      run_frame(f, 12, 1'b0, 12);
      check_frame("all_strong", 12'hFFF, 12'hFFF);
      // 5th accept at cycle a, 6th at a+1, first output visible one edge later.
      check_eq("first_latency", first_cyc - acc5_cyc, 2);
      check_eq("out_span", last_cyc - first_cyc, 11);

      mk(12'h000, 12'hFFF, 12'h000, f);
      run_frame(f, 12, 1'b0, 12);
      check_frame("all_weak", 12'h000, 12'h000);

      mk(12'h020, 12'hFDF, 12'h000, f);
      run_frame(f, 12, 1'b0, 12);
      check_frame("centre_strong", 12'h777, 12'h272);

      mk(12'h001, 12'h020, 12'h000, f);
      run_frame(f, 12, 1'b0, 12);
      check_frame("diag_only", 12'h021, 12'h001);

      mk(12'h008, 12'h050, 12'h000, f);
      run_frame(f, 12, 1'b0, 12);
      check_frame("no_wrap", 12'h048, 12'h008);

      mk(12'h800, 12'h7DF, 12'h020, f);
      run_frame(f, 12, 1'b0, 12);
      check_frame("reserved", 12'hCC0, 12'hC80);

      for (int i = 0; i < 12; i++) f[i] = 2'($urandom_range(0, 3));
      run_frame(f, 12, 1'b0, 12);
      check_frame("rand_rdy1", model_mask(f, 1'b1), model_mask(f, 1'b0));
      check_eq("rand_span", last_cyc - first_cyc, 11);
      run_frame(f, 12, 1'b1, 12);
      check_frame("rand_stall", model_mask(f, 1'b1), model_mask(f, 1'b0));

      for (int i = 0; i < 12; i++) g[i] = 2'($urandom_range(0, 3));
      mk(12'hFFF, 12'h000, 12'h000, f);
      run_frame(f, 7, 1'b0, 0);
      do_reset();
      run_frame(g, 12, 1'b0, 12);
      check_frame("after_reset", model_mask(g, 1'b1), model_mask(g, 1'b0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
